// File: rtl/spi_minion_ctrl.sv
// SPI minion word sequencer, mode 0 (CPOL=0, CPHA=0).
// Takes pre-synchronized CS/SCLK edge strobes and the MOSI level, shifts
// words in and out MSB first, and exchanges whole words with the core
// through a send val/rdy port and a one-entry receive buffer.
module spi_minion_ctrl #(
    parameter int NBITS = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cs_negedge_i,
    input  logic             cs_posedge_i,
    input  logic             sclk_posedge_i,
    input  logic             sclk_negedge_i,
    input  logic             mosi_i,
    output logic             miso_o,
    input  logic             send_val_i,
    input  logic [NBITS-1:0] send_msg_i,
    output logic             send_rdy_o,
    output logic             recv_val_o,
    output logic [NBITS-1:0] recv_msg_o,
    input  logic             recv_rdy_i,
    output logic             frame_err_o,
    output logic             overflow_o
);

    localparam int CW = $clog2(NBITS + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(NBITS - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    state_e           state_q;
    logic [CW-1:0]    bitcnt_q;
    logic [NBITS-1:0] shin_q;
    logic [NBITS-1:0] shout_q;
    logic             recv_val_q;
    logic [NBITS-1:0] recv_msg_q;
    logic             frame_err_q;
    logic             overflow_q;

    logic             active;
    logic             start;
    logic             sample;
    logic             word_done;
    logic             shift_out;
    logic             load;
    logic             cs_end;
    logic             pop;
    logic             drop;
    logic [NBITS-1:0] shin_d;
    logic [CW-1:0]    bitcnt_d;
    logic             err_d;

    // Per-cycle event decode: strobes are only meaningful in ACTIVE, and a
    // rising SCLK strobe takes priority over a falling one.
    always_comb begin
        active    = (state_q == ACTIVE);
        start     = !active && cs_negedge_i;
        sample    = active && sclk_posedge_i;
        word_done = sample && (bitcnt_q == LAST_BIT);
        shift_out = active && !sclk_posedge_i && sclk_negedge_i && (bitcnt_q != '0);
        load      = start || word_done;
        cs_end    = active && cs_posedge_i;
        pop       = recv_val_q && recv_rdy_i;
        drop      = word_done && recv_val_q && !recv_rdy_i;
        shin_d    = {shin_q[NBITS-2:0], mosi_i};

        bitcnt_d = bitcnt_q;
        if (start || word_done) begin
            bitcnt_d = '0;
        end else if (sample) begin
            bitcnt_d = bitcnt_q + 1'b1;
        end

        // Error judged on the count after any same-cycle sample.
        err_d = cs_end && (bitcnt_d != '0);
    end

    // FSM, shift registers, bit counter and receive buffer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            bitcnt_q    <= '0;
            shin_q      <= '0;
            shout_q     <= '0;
            recv_val_q  <= 1'b0;
            recv_msg_q  <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            frame_err_q <= err_d;
            overflow_q  <= drop;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (cs_end) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Leaving the frame discards any partial word count.
            bitcnt_q <= cs_end ? '0 : bitcnt_d;

            if (sample) begin
                shin_q <= shin_d;
            end

            // Load wins over shifting; with no data offered the line idles low.
            if (load) begin
                shout_q <= send_val_i ? send_msg_i : '0;
            end else if (shift_out) begin
                shout_q <= shout_q << 1;
            end

            // A full buffer not being drained keeps its old word.
            if (word_done && !drop) begin
                recv_val_q <= 1'b1;
                recv_msg_q <= shin_d;
            end else if (pop) begin
                recv_val_q <= 1'b0;
            end
        end
    end

    assign miso_o      = active && shout_q[NBITS-1];
    assign send_rdy_o  = rst_ni && load;
    assign recv_val_o  = recv_val_q;
    assign recv_msg_o  = recv_msg_q;
    assign frame_err_o = frame_err_q;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_spi_minion_ctrl.sv
// Directed bench for spi_minion_ctrl: strobes are driven on the falling
// clock edge, pulse outputs are tallied on the rising edge.
module tb_spi_minion_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b1;
    logic       cs_negedge_i = 1'b0;
    logic       cs_posedge_i = 1'b0;
    logic       sclk_posedge_i = 1'b0;
    logic       sclk_negedge_i = 1'b0;
    logic       mosi_i = 1'b0;
    logic       miso_o;
    logic       send_val_i = 1'b0;
    logic [7:0] send_msg_i = 8'h00;
    logic       send_rdy_o;
    logic       recv_val_o;
    logic [7:0] recv_msg_o;
    logic       recv_rdy_i = 1'b0;
    logic       frame_err_o;
    logic       overflow_o;

    int n_total = 0;
    int n_bad   = 0;
    int rdy_cnt = 0;
    int ferr_cnt = 0;
    int ovf_cnt = 0;
    int pop_cnt = 0;
    int r0, f0, o0, p0;
    logic [7:0] mb;

    spi_minion_ctrl #(.NBITS(8)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .cs_negedge_i   (cs_negedge_i),
        .cs_posedge_i   (cs_posedge_i),
        .sclk_posedge_i (sclk_posedge_i),
        .sclk_negedge_i (sclk_negedge_i),
        .mosi_i         (mosi_i),
        .miso_o         (miso_o),
        .send_val_i     (send_val_i),
        .send_msg_i     (send_msg_i),
        .send_rdy_o     (send_rdy_o),
        .recv_val_o     (recv_val_o),
        .recv_msg_o     (recv_msg_o),
        .recv_rdy_i     (recv_rdy_i),
        .frame_err_o    (frame_err_o),
        .overflow_o     (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (send_rdy_o)              rdy_cnt  <= rdy_cnt + 1;
        if (frame_err_o)             ferr_cnt <= ferr_cnt + 1;
        if (overflow_o)              ovf_cnt  <= ovf_cnt + 1;
        if (recv_val_o && recv_rdy_i) pop_cnt <= pop_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end else begin
            $display("pass %s: %0h", tag, got);
        end
    endtask

    task automatic snap();
        r0 = rdy_cnt; f0 = ferr_cnt; o0 = ovf_cnt; p0 = pop_cnt;
    endtask

    task automatic cs_fall();
        @(negedge clk_i); cs_negedge_i = 1'b1;
        @(negedge clk_i); cs_negedge_i = 1'b0;
    endtask

    task automatic cs_rise();
        @(negedge clk_i); cs_posedge_i = 1'b1;
        @(negedge clk_i); cs_posedge_i = 1'b0;
    endtask

    // One SCLK period; miso is captured where the master would sample it.
    task automatic do_bit(input logic m, input logic rdy_on_pos, output logic seen);
        @(negedge clk_i);
        seen = miso_o;
        mosi_i = m;
        sclk_posedge_i = 1'b1;
        if (rdy_on_pos) recv_rdy_i = 1'b1;
        @(negedge clk_i);
        sclk_posedge_i = 1'b0;
        if (rdy_on_pos) recv_rdy_i = 1'b0;
        sclk_negedge_i = 1'b1;
        @(negedge clk_i);
        sclk_negedge_i = 1'b0;
    endtask

    task automatic do_word(input logic [7:0] m, input logic rdy_last, output logic [7:0] seen);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            do_bit(m[i], rdy_last && (i == 0), s);
            seen[i] = s;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic s;
        // Reset state
        #2 rst_ni = 1'b0;
        #1;
        chk("rst_miso", miso_o, 0);
        chk("rst_send_rdy", send_rdy_o, 0);
        chk("rst_recv_val", recv_val_o, 0);
        chk("rst_recv_msg", recv_msg_o, 0);
        chk("rst_ferr", frame_err_o, 0);
        chk("rst_ovf", overflow_o, 0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);

        // 1: single word, A5 out / 3C in
        send_val_i = 1'b1; send_msg_i = 8'hA5;
        snap();
        cs_fall();
        chk("t1_rdy_start", rdy_cnt - r0, 1);
        do_word(8'h3C, 1'b0, mb);
        chk("t1_miso", mb, 8'hA5);
        chk("t1_recv_msg", recv_msg_o, 8'h3C);
        chk("t1_recv_val", recv_val_o, 1);
        chk("t1_rdy_boundary", rdy_cnt - r0, 2);
        cs_rise();
        chk("t1_ferr", ferr_cnt - f0, 0);
        chk("t1_miso_idle", miso_o, 0);
        @(negedge clk_i); recv_rdy_i = 1'b1;
        @(negedge clk_i); recv_rdy_i = 1'b0;
        chk("t1_popped", recv_val_o, 0);

        // 2: two words in one frame, new send word taken at the boundary
        recv_rdy_i = 1'b1;
        send_msg_i = 8'h96;
        snap();
        cs_fall();
        send_msg_i = 8'h69;
        do_word(8'h12, 1'b0, mb);
        chk("t2_miso_w0", mb, 8'h96);
        chk("t2_recv_w0", recv_msg_o, 8'h12);
        chk("t2_rdy_after8", rdy_cnt - r0, 2);
        do_word(8'h34, 1'b0, mb);
        chk("t2_miso_w1", mb, 8'h69);
        chk("t2_recv_w1", recv_msg_o, 8'h34);
        chk("t2_pops", pop_cnt - p0, 2);
        cs_rise();
        chk("t2_ferr", ferr_cnt - f0, 0);

        // 3: CS rises after 5 bits, then a clean frame
        snap();
        cs_fall();
        for (int i = 0; i < 5; i++) do_bit(1'b1, 1'b0, s);
        cs_rise();
        @(negedge clk_i);
        chk("t3_ferr", ferr_cnt - f0, 1);
        chk("t3_recv_val", recv_val_o, 0);
        chk("t3_no_pop", pop_cnt - p0, 0);
        chk("t3_miso_idle", miso_o, 0);
        cs_fall();
        do_word(8'hC3, 1'b0, mb);
        chk("t3_recv_next", recv_msg_o, 8'hC3);
        chk("t3_pop_next", pop_cnt - p0, 1);
        cs_rise();
        chk("t3_ferr_once", ferr_cnt - f0, 1);

        // 4: buffer full, second word dropped
        recv_rdy_i = 1'b0;
        snap();
        cs_fall();
        do_word(8'h11, 1'b0, mb);
        chk("t4_ovf_none", ovf_cnt - o0, 0);
        do_word(8'h22, 1'b0, mb);
        chk("t4_ovf", ovf_cnt - o0, 1);
        chk("t4_recv_kept", recv_msg_o, 8'h11);
        chk("t4_recv_val", recv_val_o, 1);
        cs_rise();
        @(negedge clk_i); recv_rdy_i = 1'b1;
        @(negedge clk_i); recv_rdy_i = 1'b0;
        chk("t4_popped", recv_val_o, 0);

        // 5: nothing to send; then push and pop in the same cycle
        send_val_i = 1'b0; send_msg_i = 8'hFF;
        snap();
        cs_fall();
        do_word(8'h7E, 1'b0, mb);
        chk("t5_miso_zero", mb, 8'h00);
        chk("t5_recv_w0", recv_msg_o, 8'h7E);
        do_word(8'h81, 1'b1, mb);
        chk("t5_miso_zero_w1", mb, 8'h00);
        chk("t5_recv_val", recv_val_o, 1);
        chk("t5_recv_w1", recv_msg_o, 8'h81);
        chk("t5_ovf", ovf_cnt - o0, 0);
        chk("t5_pop", pop_cnt - p0, 1);
        cs_rise();

        // 6: asynchronous reset mid-word with a word buffered
        send_val_i = 1'b1; send_msg_i = 8'hFF;
        cs_fall();
        for (int i = 0; i < 3; i++) do_bit(1'b0, 1'b0, s);
        chk("t6_miso_pre", miso_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("t6_miso", miso_o, 0);
        chk("t6_recv_val", recv_val_o, 0);
        chk("t6_recv_msg", recv_msg_o, 0);
        chk("t6_send_rdy", send_rdy_o, 0);
        @(negedge clk_i); rst_ni = 1'b1;
        @(negedge clk_i);
        chk("t6_idle_miso", miso_o, 0);
        send_msg_i = 8'hB4;
        cs_fall();
        do_word(8'h5C, 1'b0, mb);
        chk("t6_miso_after", mb, 8'hB4);
        chk("t6_recv_after", recv_msg_o, 8'h5C);
        cs_rise();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
